icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Line-refill engine for the instruction cache.
- On an icache miss it fetches one 256-bit line (8 x 32-bit words) from memory as a Wishbone B3 initiator using an incrementing burst.
- It assembles the words into a line and drives the icache write port (`wr_data`/`we`) with the two-cycle write timing the icache requires.
- It stalls the core with `freeze_out` until the line is written.

Parameters:
- RETRY_MAX, 4, number of `wb_rty_i` terminations tolerated per beat before the refill is aborted with an error.
- TIMEOUT, 255, cycles without a termination on an active beat before abort; range 1..255, counter is 8 bits.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous reset, active-high (asserted = 1)
- miss_req  input  1  refill request, level; sampled only in IDLE
- miss_paddr  input  32  physical miss address; bits [4:0] ignored
- busy  output  1  refill in progress (any state other than IDLE)
- freeze_out  output  1  core stall; equals busy
- line_data  output  256  assembled line, connects to icache `wr_data`
- line_we  output  1  one-cycle write strobe, connects to icache `we`
- refill_done  output  1  one-cycle pulse when the line write completes
- refill_err  output  1  one-cycle pulse when the refill aborts
- wb_cyc_o  output  1  Wishbone cycle
- wb_stb_o  output  1  Wishbone strobe
- wb_we_o  output  1  Wishbone write enable; constant 0
- wb_adr_o  output  32  Wishbone address
- wb_sel_o  output  4  Wishbone byte selects; constant 4'hF
- wb_cti_o  output  3  Wishbone cycle type identifier
- wb_bte_o  output  2  Wishbone burst type; constant 2'b00 (linear)
- wb_dat_o  output  32  Wishbone write data; constant 0
- wb_ack_i  input  1  Wishbone normal termination
- wb_err_i  input  1  Wishbone error termination
- wb_rty_i  input  1  Wishbone retry termination
- wb_dat_i  input  32  Wishbone read data

Behaviour:
- Reset: all outputs 0, `line_data` = 0, state IDLE, beat/retry/timeout counters 0. Reset overrides every state, including mid-burst; `cyc`/`stb` are low after the first reset edge.
- States: IDLE, BURST, RTYGAP, WRITE, HOLD.
- IDLE:
  - If `miss_req` = 1, latch `base = miss_paddr[31:5]`, clear beat=0, retry=0, tmo=0, and go to BURST.
  - `busy` rises in the cycle after `miss_req` is sampled.
- BURST:
  - Drive `cyc` = `stb` = 1 and `adr = {base, beat[2:0], 2'b00}`.
  - `cti` = 3'b010 for beats 0..6 and 3'b111 for beat 7.
  - Termination priority when several are asserted together: err > rty > ack.
  - ack: `line_data[32*beat+31 : 32*beat] <= wb_dat_i`, beat+1, retry=0, tmo=0. On beat 7, drop `cyc`/`stb` and go to WRITE.
  - rty: retry+1. If the new count exceeds RETRY_MAX, abort. Otherwise go to RTYGAP.
  - err: abort.
  - No termination: tmo+1; when tmo reaches TIMEOUT, abort.
- RTYGAP:
  - One cycle with `stb` = 0 and `cyc` = 1; `cti` held at its beat value; tmo=0.
  - Return to BURST and re-issue the same beat. Words already captured are kept.
- Abort:
  - Next cycle `cyc` = `stb` = 0, `refill_err` pulses once, return to IDLE.
  - No `line_we`; `line_data` is left partially updated.
- WRITE: `line_we` = 1 for exactly one cycle, `line_data` stable, then go to HOLD. The icache moves to its write state on this strobe.
- HOLD:
  - One cycle with `line_we` = 0 and `line_data` still stable; the icache commits data and tag in this cycle.
  - Pulse `refill_done`, go to IDLE, and `busy` drops.
- Latency: a zero-wait-state slave completes the refill with `busy` high for 11 cycles (1 setup + 8 beats + WRITE + HOLD).
- `miss_req` while `busy` is ignored; the requester keeps it high until it sees `refill_done` or `refill_err`.
- Word ordering is fixed: word 0 comes from address offset 0 and maps to `line_data[31:0]`. No critical-word-first.
- Terminations while `stb` = 0 (RTYGAP) or in IDLE/WRITE/HOLD are ignored.

Test Plan:
- Zero-wait slave, `miss_paddr` = 32'h0000_1234: addresses 0x1220, 0x1224, … 0x123C; `cti` 010 x7 then 111; `line_data[31:0]` = word@0x1220; `line_we` one cycle; `refill_done` 11 cycles after request; `busy` then 0.
- Slave inserts 3 wait states on beat 2: `stb` held, `adr` = base+8 held through the wait states; line correct; total `busy` = 14 cycles.
- `wb_rty_i` on beat 4 twice, then ack: two RTYGAP cycles with `stb` low, beat 4 re-issued at the same address; `refill_done` and no `refill_err`.
- `wb_rty_i` asserted 5 times on one beat (RETRY_MAX = 4): `refill_err` pulses, `line_we` never asserts, `cyc` low, state IDLE.
- `wb_err_i` and `wb_ack_i` together on beat 1: error wins, abort. Separately, no termination for 255 cycles: timeout abort with `refill_err`.
- `rst_n` asserted during beat 5: next cycle `cyc`/`stb`/`busy`/`line_data` = 0. A new `miss_req` after reset restarts at beat 0.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Bundle between the icache refill engine, the icache/core side and the Wishbone B3 bus.
// The master modport is the refill engine, the slave modport is everything around it.
interface icache_refill_ctrl_if;
    logic         miss_req;
    logic [31:0]  miss_paddr;
    logic         busy;
    logic         freeze_out;
    logic [255:0] line_data;
    logic         line_we;
    logic         refill_done;
    logic         refill_err;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_we_o;
    logic [31:0]  wb_adr_o;
    logic [3:0]   wb_sel_o;
    logic [2:0]   wb_cti_o;
    logic [1:0]   wb_bte_o;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_i;
    logic         wb_err_i;
    logic         wb_rty_i;
    logic [31:0]  wb_dat_i;

    modport master (
        input  miss_req, miss_paddr, wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
        output busy, freeze_out, line_data, line_we, refill_done, refill_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_dat_o
    );

    modport slave (
        output miss_req, miss_paddr, wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
        input  busy, freeze_out, line_data, line_we, refill_done, refill_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_dat_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache line refill: 8-beat Wishbone B3 incrementing burst read, then a one-cycle line write strobe.
// Latency 11 cycles at zero wait; slave wait states stretch the burst, rty/err/timeout abort it.
module icache_refill_ctrl #(
    parameter int RETRY_MAX = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_refill_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, BURST, RTYGAP, WRITE, HOLD} state_t;

    localparam logic [3:0] RTY_LIM  = 4'(RETRY_MAX);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t         state;
    logic [26:0]    base;
    logic [2:0]     beat;
    logic [3:0]     retry;
    logic [7:0]     tmo;
    logic           busy_q;
    logic           cyc_q;
    logic           stb_q;
    logic           we_q;
    logic           done_q;
    logic           err_q;
    logic [31:0]    adr_q;
    logic [2:0]     cti_q;
    logic [255:0]   line_q;
    logic           abort;
    logic           unused_paddr;

    assign unused_paddr = ^bus.miss_paddr[4:0];

    // Only a strobed beat can terminate; err beats rty beats ack.
    always_comb begin
        abort = 1'b0;
        if (state == BURST && stb_q) begin
            abort = bus.wb_err_i
                 || (bus.wb_rty_i && retry >= RTY_LIM)
                 || (!bus.wb_ack_i && !bus.wb_rty_i && tmo == TMO_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            base   <= '0;
            beat   <= '0;
            retry  <= '0;
            tmo    <= '0;
            busy_q <= 1'b0;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            adr_q  <= '0;
            cti_q  <= '0;
            line_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                cyc_q  <= 1'b0;
                stb_q  <= 1'b0;
                busy_q <= 1'b0;
                err_q  <= 1'b0 | 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.miss_req) begin
                            base   <= bus.miss_paddr[31:5];
                            beat   <= '0;
                            retry  <= '0;
                            tmo    <= '0;
                            busy_q <= 1'b1;
                            state  <= BURST;
                        end
                    end
                    BURST: begin
                        // First BURST cycle is the setup cycle that launches beat 0.
                        if (!stb_q) begin
                            cyc_q <= 1'b1;
                            stb_q <= 1'b1;
                            adr_q <= {base, beat, 2'b00};
                            cti_q <= (beat == 3'd7) ? 3'b111 : 3'b010;
                        end else if (bus.wb_rty_i) begin
                            retry <= retry + 4'd1;
                            tmo   <= '0;
                            stb_q <= 1'b0;
                            state <= RTYGAP;
                        end else if (bus.wb_ack_i) begin
                            for (int i = 0; i < 8; i++) begin
                                if (beat == 3'(i)) line_q[32*i +: 32] <= bus.wb_dat_i;
                            end
                            retry <= '0;
                            tmo   <= '0;
                            if (beat == 3'd7) begin
                                cyc_q <= 1'b0;
                                stb_q <= 1'b0;
                                we_q  <= 1'b1;
                                state <= WRITE;
                            end else begin
                                beat  <= beat + 3'd1;
                                adr_q <= {base, beat + 3'd1, 2'b00};
                                cti_q <= (beat == 3'd6) ? 3'b111 : 3'b010;
                            end
                        end else begin
                            tmo <= tmo + 8'd1;
                        end
                    end
                    RTYGAP: begin
                        stb_q <= 1'b1;
                        tmo   <= '0;
                        state <= BURST;
                    end
                    WRITE: state <= HOLD;
                    HOLD: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.freeze_out  = busy_q;
    assign bus.line_data   = line_q;
    assign bus.line_we     = we_q;
    assign bus.refill_done = done_q;
    assign bus.refill_err  = err_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_we_o     = 1'b0;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_sel_o    = 4'hF;
    assign bus.wb_cti_o    = cti_q;
    assign bus.wb_bte_o    = 2'b00;
    assign bus.wb_dat_o    = '0;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: scripted and randomized Wishbone slave against a transaction-level line model.
module tb_icache_refill_ctrl;
    localparam int RMAX = 4;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_refill_ctrl_if bus ();
    icache_refill_ctrl #(.RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave behaviour knobs: per-beat scripts plus random percentages.
    int p_err = 0, p_rty = 0, p_wait = 0, p_noise = 0;
    int wait_beat = -1, wait_n = 0, rty_beat = -1, rty_n = 0, err_beat = -1;
    bit silent = 1'b0;
    int waited = 0, rtyd = 0;

    always @(posedge clk) begin
        int bt;
        int r;
        #1;
        bus.wb_ack_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = $urandom;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            bt = int'(bus.wb_adr_o[4:2]);
            r  = $urandom_range(99);
            if (silent) begin
                bus.wb_ack_i = 1'b0;
            end else if (bt == err_beat) begin
                bus.wb_err_i = 1'b1;
                bus.wb_ack_i = 1'b1;
            end else if (bt == wait_beat && waited < wait_n) begin
                waited++;
            end else if (bt == rty_beat && rtyd < rty_n) begin
                bus.wb_rty_i = 1'b1;
                rtyd++;
            end else if (r < p_err) begin
                bus.wb_err_i = 1'b1;
                bus.wb_ack_i = 1'($urandom);
                bus.wb_rty_i = 1'($urandom);
            end else if (r < p_err + p_rty) begin
                bus.wb_rty_i = 1'b1;
                bus.wb_ack_i = 1'($urandom);
            end else if (r >= p_err + p_rty + p_wait) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = mem(bus.wb_adr_o);
            end
        end else if ($urandom_range(99) < p_noise) begin
            bus.wb_ack_i = 1'($urandom);
            bus.wb_rty_i = 1'($urandom);
            bus.wb_err_i = 1'($urandom);
        end
    end

    // Reference model: what the refill must look like, tracked per word of the line.
    bit          e_busy, e_cyc, e_stb, e_we, e_done, e_err;
    logic [26:0] m_base;
    logic [2:0]  m_word;
    int          m_tries, m_quiet, m_tail;
    logic [31:0] m_line [8];

    task automatic m_abort();
        e_cyc  = 1'b0;
        e_stb  = 1'b0;
        e_busy = 1'b0;
        e_err  = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            e_busy = 0; e_cyc = 0; e_stb = 0; e_we = 0; e_done = 0; e_err = 0;
            m_base = '0; m_word = '0; m_tries = 0; m_quiet = 0; m_tail = 0;
            for (int i = 0; i < 8; i++) m_line[i] = '0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (!e_busy) begin
                if (bus.miss_req) begin
                    e_busy = 1'b1;
                    m_base = bus.miss_paddr[31:5];
                    m_word = '0;
                    m_tries = 0;
                    m_quiet = 0;
                end
            end else if (m_tail == 1) begin
                e_we = 1'b0;
                m_tail = 2;
            end else if (m_tail == 2) begin
                e_busy = 1'b0;
                e_done = 1'b1;
                m_tail = 0;
            end else if (!e_stb) begin
                e_cyc = 1'b1;
                e_stb = 1'b1;
            end else if (bus.wb_err_i) begin
                m_abort();
            end else if (bus.wb_rty_i) begin
                m_tries++;
                m_quiet = 0;
                if (m_tries > RMAX) m_abort();
                else e_stb = 1'b0;
            end else if (bus.wb_ack_i) begin
                m_line[m_word] = mem({m_base, m_word, 2'b00});
                m_tries = 0;
                m_quiet = 0;
                if (m_word == 3'd7) begin
                    e_cyc = 1'b0;
                    e_stb = 1'b0;
                    e_we  = 1'b1;
                    m_tail = 1;
                end else begin
                    m_word++;
                end
            end else begin
                m_quiet++;
                if (m_quiet >= TMO) m_abort();
            end
        end
    end

    int          busy_cnt, gap_cnt, we_cnt, watch_hits;
    bit          saw_done, saw_err, have_first;
    logic [31:0] first_adr, last_adr, watch_adr;
    logic [2:0]  first_cti, last_cti;

    always @(negedge clk) begin
        logic [255:0] el;
        if (chk_en) begin
            for (int i = 0; i < 8; i++) el[32*i +: 32] = m_line[i];
            chk("busy", 256'(bus.busy), 256'(e_busy));
            chk("freeze_out", 256'(bus.freeze_out), 256'(e_busy));
            chk("cyc", 256'(bus.wb_cyc_o), 256'(e_cyc));
            chk("stb", 256'(bus.wb_stb_o), 256'(e_stb));
            chk("line_we", 256'(bus.line_we), 256'(e_we));
            chk("refill_done", 256'(bus.refill_done), 256'(e_done));
            chk("refill_err", 256'(bus.refill_err), 256'(e_err));
            chk("line_data", bus.line_data, el);
            chk("wb_static", 256'({bus.wb_we_o, bus.wb_sel_o, bus.wb_bte_o, bus.wb_dat_o}),
                256'({1'b0, 4'hF, 2'b00, 32'h0}));
            if (e_cyc) begin
                chk("adr", 256'(bus.wb_adr_o), 256'({m_base, m_word, 2'b00}));
                chk("cti", 256'(bus.wb_cti_o), 256'((m_word == 3'd7) ? 3'b111 : 3'b010));
            end
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b0) gap_cnt++;
        if (bus.line_we === 1'b1) we_cnt++;
        if (bus.refill_done === 1'b1) saw_done = 1'b1;
        if (bus.refill_err === 1'b1) saw_err = 1'b1;
        if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1) begin
            if (!have_first) begin
                first_adr = bus.wb_adr_o;
                first_cti = bus.wb_cti_o;
                have_first = 1'b1;
            end
            last_adr = bus.wb_adr_o;
            last_cti = bus.wb_cti_o;
            if (bus.wb_adr_o == watch_adr) watch_hits++;
        end
    end

    // Requester holds miss_req until it sees done/err and scrambles miss_paddr while busy.
    task automatic do_refill(input logic [31:0] pa, input int budget);
        int n;
        bit ended;
        busy_cnt = 0; gap_cnt = 0; we_cnt = 0; watch_hits = 0;
        saw_done = 0; saw_err = 0; have_first = 0; waited = 0; rtyd = 0;
        @(posedge clk);
        #1;
        bus.miss_req   = 1'b1;
        bus.miss_paddr = pa;
        n = 0;
        ended = 1'b0;
        while (!ended && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.refill_done || bus.refill_err) ended = 1'b1;
            else if (bus.busy) bus.miss_paddr = $urandom;
        end
        bus.miss_req = 1'b0;
        #1;
        chk("refill_ends_in_budget", 256'(ended), 256'(1));
    endtask

    initial begin
        bit found;
        int n;
        rst_n = 1'b1;
        bus.miss_req = 1'b0;
        bus.miss_paddr = '0;
        watch_adr = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_cyc_stb", 256'({bus.wb_cyc_o, bus.wb_stb_o}), 256'(0));
        chk("rst_line", bus.line_data, 256'(0));
        #1;

        // Zero-wait refill of the 0x1220 line.
        do_refill(32'h0000_1234, 100);
        chk("t1_busy_cycles", 256'(busy_cnt), 256'(11));
        chk("t1_done", 256'(saw_done), 256'(1));
        chk("t1_no_err", 256'(saw_err), 256'(0));
        chk("t1_we_count", 256'(we_cnt), 256'(1));
        chk("t1_first_adr", 256'(first_adr), 256'(32'h0000_1220));
        chk("t1_first_cti", 256'(first_cti), 256'(3'b010));
        chk("t1_last_adr", 256'(last_adr), 256'(32'h0000_123C));
        chk("t1_last_cti", 256'(last_cti), 256'(3'b111));
        chk("t1_word0", 256'(bus.line_data[31:0]), 256'(32'h1220_EDDF));
        chk("t1_word7", 256'(bus.line_data[255:224]), 256'(32'h123C_EDC3));
        chk("t1_model_word0", 256'(m_line[0]), 256'(32'h1220_EDDF));
        chk("t1_idle_after", 256'(bus.busy), 256'(0));

        // Three wait states on beat 2.
        wait_beat = 2; wait_n = 3; watch_adr = 32'h0004_00E8;
        do_refill(32'h0004_00E0, 100);
        chk("t2_busy_cycles", 256'(busy_cnt), 256'(14));
        chk("t2_beat2_held", 256'(watch_hits), 256'(4));
        chk("t2_done", 256'(saw_done), 256'(1));
        wait_beat = -1;

        // Two retries on beat 4, then ack.
        rty_beat = 4; rty_n = 2; watch_adr = 32'h0ABC_DE50;
        do_refill(32'h0ABC_DE40, 100);
        chk("t3_busy_cycles", 256'(busy_cnt), 256'(15));
        chk("t3_gap_cycles", 256'(gap_cnt), 256'(2));
        chk("t3_beat4_reissued", 256'(watch_hits), 256'(3));
        chk("t3_done_no_err", 256'({saw_done, saw_err}), 256'(2'b10));

        // Five retries on beat 0 exceed the limit.
        rty_beat = 0; rty_n = 5;
        do_refill(32'h0000_2000, 100);
        chk("t4_busy_cycles", 256'(busy_cnt), 256'(10));
        chk("t4_gap_cycles", 256'(gap_cnt), 256'(4));
        chk("t4_err_no_done", 256'({saw_err, saw_done}), 256'(2'b10));
        chk("t4_no_we", 256'(we_cnt), 256'(0));
        chk("t4_bus_idle", 256'({bus.wb_cyc_o, bus.busy}), 256'(0));
        rty_beat = -1;

        // err together with ack on beat 1.
        err_beat = 1;
        do_refill(32'h0000_3000, 100);
        chk("t5_busy_cycles", 256'(busy_cnt), 256'(3));
        chk("t5_err", 256'(saw_err), 256'(1));
        chk("t5_no_we", 256'(we_cnt), 256'(0));
        chk("t5_word0_kept", 256'(bus.line_data[31:0]), 256'(32'h3000_CFFF));
        err_beat = -1;

        // Silent slave: timeout abort.
        silent = 1'b1;
        do_refill(32'h0000_4000, 400);
        chk("t6_busy_cycles", 256'(busy_cnt), 256'(256));
        chk("t6_err", 256'(saw_err), 256'(1));
        silent = 1'b0;

        // Reset during beat 5, then restart.
        @(posedge clk);
        #1;
        bus.miss_req = 1'b1;
        bus.miss_paddr = 32'h0000_8000;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_adr_o[4:2] == 3'd5) found = 1'b1;
        end
        chk("t7_reached_beat5", 256'(found), 256'(1));
        rst_n = 1'b1;
        bus.miss_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_cyc_stb", 256'({bus.wb_cyc_o, bus.wb_stb_o}), 256'(0));
        chk("t7_rst_busy", 256'(bus.busy), 256'(0));
        chk("t7_rst_line", bus.line_data, 256'(0));
        #1;
        do_refill(32'h0000_8000, 100);
        chk("t7_restart_adr", 256'(first_adr), 256'(32'h0000_8000));
        chk("t7_restart_busy", 256'(busy_cnt), 256'(11));
        chk("t7_restart_done", 256'(saw_done), 256'(1));

        // Randomized slaves: waits, retries, errors and stray terminations.
        for (int k = 0; k < 40; k++) begin
            p_err   = $urandom_range(3);
            p_rty   = (k % 4 == 0) ? 50 : $urandom_range(15);
            p_wait  = $urandom_range(40);
            p_noise = $urandom_range(50);
            do_refill($urandom, 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
